// File: rtl/vliw_pkg.sv
// Shared definitions for the N-slot VLIW core: opcode encoding, default sizes
// and slot field offsets (LSB first: op, dest, src1, src2, imm, valid on top).
package vliw_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_MUL  = 3'b001,
        OP_ADDI = 3'b010,
        OP_SUB  = 3'b011,
        OP_MOV  = 3'b100,
        OP_AND  = 3'b101,
        OP_OR   = 3'b110,
        OP_XOR  = 3'b111
    } op_e;

    localparam int NUM_SLOTS_DEF = 4;
    localparam int XLEN_DEF      = 32;
    localparam int NUM_REGS_DEF  = 8;
    localparam int IMM_W_DEF     = 19;
    localparam int CNT_W_DEF     = 16;
    localparam int OP_W          = 3;

    function automatic int slot_w(input int ra_w, input int imm_w);
        return 1 + imm_w + 3 * ra_w + OP_W;
    endfunction

    function automatic int off_dest();
        return OP_W;
    endfunction

    function automatic int off_src1(input int ra_w);
        return OP_W + ra_w;
    endfunction

    function automatic int off_src2(input int ra_w);
        return OP_W + 2 * ra_w;
    endfunction

    function automatic int off_imm(input int ra_w);
        return OP_W + 3 * ra_w;
    endfunction

endpackage

// File: rtl/vliw_slot_alu.sv
// Combinational per-slot ALU. With VLIW_MUL_EN undefined no multiplier is built
// and op 001 reports illegal instead of writing.
module vliw_slot_alu
    import vliw_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int IMM_W = IMM_W_DEF
) (
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic [XLEN-1:0]  result_o,
    output logic             we_o,
    output logic             illegal_o
);

    logic [XLEN-1:0] imm_ext;
    assign imm_ext = XLEN'(imm_i);

    always_comb begin
        result_o  = '0;
        we_o      = 1'b1;
        illegal_o = 1'b0;
        case (op_e'(op_i))
            OP_ADD:  result_o = a_i + b_i;
`ifdef VLIW_MUL_EN
            OP_MUL:  result_o = a_i * b_i;
`else
            OP_MUL: begin
                we_o      = 1'b0;
                illegal_o = 1'b1;
            end
`endif
            OP_ADDI: result_o = a_i + imm_ext;
            OP_SUB:  result_o = a_i - b_i;
            OP_MOV:  result_o = imm_ext;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/vliw_core_nslot.sv
// N-slot VLIW core: IF latch -> ID decode -> EX/WB against a shared register file.
// Optional multiplier enabled by defining VLIW_MUL_EN.
module vliw_core_nslot
    import vliw_pkg::*;
#(
    parameter  int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter  int XLEN      = XLEN_DEF,
    parameter  int NUM_REGS  = NUM_REGS_DEF,
    parameter  int IMM_W     = IMM_W_DEF,
    parameter  int CNT_W     = CNT_W_DEF,
    localparam int RA_W      = $clog2(NUM_REGS),
    localparam int SLOT_W    = slot_w(RA_W, IMM_W)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_SLOTS*SLOT_W-1:0] bundle_i,
    input  logic                        bundle_valid_i,
    output logic                        bundle_ready_o,
    input  logic                        hold_i,
    input  logic [RA_W-1:0]             dbg_raddr_i,
    output logic [XLEN-1:0]             dbg_rdata_o,
    output logic                        retire_o,
    output logic [NUM_SLOTS-1:0]        retire_mask_o,
    output logic [CNT_W-1:0]            retire_cnt_o,
    output logic                        waw_o,
    output logic                        illegal_o
);

    localparam int OFF_DEST = off_dest();
    localparam int OFF_S1   = off_src1(RA_W);
    localparam int OFF_S2   = off_src2(RA_W);
    localparam int OFF_IMM  = off_imm(RA_W);

    logic                                if_vld_q;
    logic [NUM_SLOTS-1:0][SLOT_W-1:0]    if_slot_q;

    logic [NUM_SLOTS-1:0]                dec_sv;
    logic [NUM_SLOTS-1:0][2:0]           dec_op;
    logic [NUM_SLOTS-1:0][RA_W-1:0]      dec_dest, dec_src1, dec_src2;
    logic [NUM_SLOTS-1:0][IMM_W-1:0]     dec_imm;

    logic                                id_vld_q;
    logic [NUM_SLOTS-1:0]                id_sv_q;
    logic [NUM_SLOTS-1:0][2:0]           id_op_q;
    logic [NUM_SLOTS-1:0][RA_W-1:0]      id_dest_q, id_src1_q, id_src2_q;
    logic [NUM_SLOTS-1:0][IMM_W-1:0]     id_imm_q;

    logic [NUM_REGS-1:0][XLEN-1:0]       rf_q, rf_d;
    logic [NUM_SLOTS-1:0][XLEN-1:0]      alu_res;
    logic [NUM_SLOTS-1:0]                alu_we, alu_ill, commit;
    logic                                waw_hit, ill_hit;

    logic                                retire_q;
    logic [NUM_SLOTS-1:0]                mask_q;
    logic [CNT_W-1:0]                    cnt_q;
    logic                                waw_q, ill_q;

    assign bundle_ready_o = !hold_i;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        assign dec_sv[s]   = if_slot_q[s][SLOT_W-1];
        assign dec_op[s]   = if_slot_q[s][2:0];
        assign dec_dest[s] = if_slot_q[s][OFF_DEST +: RA_W];
        assign dec_src1[s] = if_slot_q[s][OFF_S1 +: RA_W];
        assign dec_src2[s] = if_slot_q[s][OFF_S2 +: RA_W];
        assign dec_imm[s]  = if_slot_q[s][OFF_IMM +: IMM_W];

        // Operands come from the pre-bundle RF, giving parallel slot semantics.
        vliw_slot_alu #(
            .XLEN  (XLEN),
            .IMM_W (IMM_W)
        ) u_alu (
            .op_i      (id_op_q[s]),
            .a_i       (rf_q[id_src1_q[s]]),
            .b_i       (rf_q[id_src2_q[s]]),
            .imm_i     (id_imm_q[s]),
            .result_o  (alu_res[s]),
            .we_o      (alu_we[s]),
            .illegal_o (alu_ill[s])
        );
    end

    assign commit  = id_sv_q & alu_we;
    assign ill_hit = |(id_sv_q & alu_ill);

    // Ascending slot order lets the highest committing slot win a shared dest.
    always_comb begin
        rf_d    = rf_q;
        waw_hit = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (commit[s]) rf_d[id_dest_q[s]] = alu_res[s];
            for (int t = 0; t < s; t++) begin
                if (commit[s] && commit[t] && (id_dest_q[s] == id_dest_q[t])) waw_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            if_vld_q  <= 1'b0;
            if_slot_q <= '0;
            id_vld_q  <= 1'b0;
            id_sv_q   <= '0;
            id_op_q   <= '0;
            id_dest_q <= '0;
            id_src1_q <= '0;
            id_src2_q <= '0;
            id_imm_q  <= '0;
            rf_q      <= '0;
            retire_q  <= 1'b0;
            mask_q    <= '0;
            cnt_q     <= '0;
            waw_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else if (hold_i) begin
            retire_q <= 1'b0;
        end else begin
            if_vld_q  <= bundle_valid_i;
            if_slot_q <= bundle_i;
            id_vld_q  <= if_vld_q;
            id_sv_q   <= dec_sv;
            id_op_q   <= dec_op;
            id_dest_q <= dec_dest;
            id_src1_q <= dec_src1;
            id_src2_q <= dec_src2;
            id_imm_q  <= dec_imm;
            retire_q  <= id_vld_q;
            if (id_vld_q) begin
                rf_q   <= rf_d;
                mask_q <= commit;
                cnt_q  <= cnt_q + 1'b1;
                waw_q  <= waw_q | waw_hit;
                ill_q  <= ill_q | ill_hit;
            end
        end
    end

    assign dbg_rdata_o   = rf_q[dbg_raddr_i];
    assign retire_o      = retire_q;
    assign retire_mask_o = mask_q;
    assign retire_cnt_o  = cnt_q;
    assign waw_o         = waw_q;
    assign illegal_o     = ill_q;

endmodule

// File: tb/tb_vliw_core_nslot.sv
// Directed + random bench for vliw_core_nslot; a bundle-level model predicts
// retire timing, masks, counter, sticky flags and the full register file.
module tb_vliw_core_nslot;

    localparam int NS = 4;
    localparam int XL = 32;
    localparam int NR = 8;
    localparam int IW = 19;
    localparam int CW = 16;
    localparam int SW = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [NS*SW-1:0] bundle_i = '0;
    logic             bundle_valid_i = 1'b0;
    logic             bundle_ready_o;
    logic             hold_i = 1'b0;
    logic [2:0]       dbg_raddr_i = '0;
    logic [XL-1:0]    dbg_rdata_o;
    logic             retire_o;
    logic [NS-1:0]    retire_mask_o;
    logic [CW-1:0]    retire_cnt_o;
    logic             waw_o;
    logic             illegal_o;

    always #10 clk = ~clk;

    vliw_core_nslot dut (
        .clk            (clk),
        .rstn           (rstn),
        .bundle_i       (bundle_i),
        .bundle_valid_i (bundle_valid_i),
        .bundle_ready_o (bundle_ready_o),
        .hold_i         (hold_i),
        .dbg_raddr_i    (dbg_raddr_i),
        .dbg_rdata_o    (dbg_rdata_o),
        .retire_o       (retire_o),
        .retire_mask_o  (retire_mask_o),
        .retire_cnt_o   (retire_cnt_o),
        .waw_o          (waw_o),
        .illegal_o      (illegal_o)
    );

    typedef struct {
        logic [NS*SW-1:0] b;
        int               due;
    } inflight_t;

    inflight_t     pend[$];
    logic [XL-1:0] mrf[NR];
    int unsigned   mcnt;
    bit            mwaw, mill;
    int            active;
    logic [NS-1:0] last_mask;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] sl(input bit v, input logic [2:0] op, input logic [2:0] d,
                                         input logic [2:0] s1, input logic [2:0] s2,
                                         input logic [IW-1:0] imm);
        return {v, imm, s2, s1, d, op};
    endfunction

    // Bundle semantics straight from the ISA rules: read old RF, later slots overwrite.
    task automatic retire_model(input logic [NS*SW-1:0] b, output logic [NS-1:0] mask);
        logic [XL-1:0] old[NR];
        bit            wr[NR];
        logic [SW-1:0] x;
        logic [XL-1:0] res, immx;
        logic [2:0]    d, s1, s2;
        bit            ok;
        old  = mrf;
        mask = '0;
        for (int r = 0; r < NR; r++) wr[r] = 1'b0;
        for (int s = 0; s < NS; s++) begin
            x = b[s*SW +: SW];
            if (!x[31]) continue;
            immx = {13'b0, x[30:12]};
            s2 = x[11:9]; s1 = x[8:6]; d = x[5:3];
            ok = 1'b1;
            res = '0;
            case (x[2:0])
                3'd0: res = old[s1] + old[s2];
`ifdef VLIW_MUL_EN
                3'd1: res = old[s1] * old[s2];
`else
                3'd1: begin ok = 1'b0; mill = 1'b1; end
`endif
                3'd2: res = old[s1] + immx;
                3'd3: res = old[s1] - old[s2];
                3'd4: res = immx;
                3'd5: res = old[s1] & old[s2];
                3'd6: res = old[s1] | old[s2];
                default: res = old[s1] ^ old[s2];
            endcase
            if (ok) begin
                if (wr[d]) mwaw = 1'b1;
                wr[d]   = 1'b1;
                mrf[d]  = res;
                mask[s] = 1'b1;
            end
        end
        mcnt = (mcnt + 1) % (1 << CW);
    endtask

    task automatic tick();
        bit               acc, hld, rst, exp_ret;
        logic [NS*SW-1:0] b;
        logic [NS-1:0]    m;
        #1;
        if (rstn) chk("ready", bundle_ready_o, !hold_i);
        acc = bundle_valid_i && !hold_i;
        hld = hold_i;
        rst = !rstn;
        b   = bundle_i;
        m   = '0;
        @(posedge clk);
        #1;
        exp_ret = 1'b0;
        if (rst) begin
            for (int r = 0; r < NR; r++) mrf[r] = '0;
            pend.delete();
            mcnt = 0; mwaw = 1'b0; mill = 1'b0;
        end else if (!hld) begin
            active++;
            if (acc) pend.push_back('{b, active + 2});
            if (pend.size() > 0 && pend[0].due == active) begin
                exp_ret = 1'b1;
                retire_model(pend[0].b, m);
                void'(pend.pop_front());
            end
        end
        chk("retire", retire_o, exp_ret);
        if (exp_ret) begin
            chk("mask", retire_mask_o, m);
            last_mask = retire_mask_o;
        end
        chk("cnt", retire_cnt_o, mcnt);
        chk("waw", waw_o, mwaw);
        chk("illegal", illegal_o, mill);
        for (int r = 0; r < NR; r++) begin
            dbg_raddr_i = 3'(r);
            #1;
            chk($sformatf("rf%0d", r), dbg_rdata_o, mrf[r]);
        end
    endtask

    task automatic send(input logic [NS*SW-1:0] b);
        bundle_i = b;
        bundle_valid_i = 1'b1;
        tick();
        bundle_valid_i = 1'b0;
    endtask

    task automatic rd(input int r, output logic [XL-1:0] v);
        dbg_raddr_i = 3'(r);
        #1;
        v = dbg_rdata_o;
    endtask

    logic [XL-1:0]    v;
    logic [NS*SW-1:0] rb;
    logic [SW-1:0]    z;

    initial begin
        z = '0;
        active = 0;
        last_mask = '0;
        // 1+2: two bundles back to back, the second consuming the first's results
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        send({z, sl(1, 4, 3, 0, 0, 0), sl(1, 4, 2, 0, 0, 7), sl(1, 4, 1, 0, 0, 5)});
        send({z, sl(1, 7, 6, 1, 2, 0), sl(1, 3, 5, 1, 2, 0), sl(1, 0, 4, 1, 2, 0)});
        repeat (2) tick();
        chk("t1_cnt", retire_cnt_o, 2);
        chk("t1_mask", last_mask, 4'b0111);
        rd(1, v); chk("t1_r1", v, 5);
        rd(2, v); chk("t1_r2", v, 7);
        rd(4, v); chk("t2_r4", v, 12);
        rd(5, v); chk("t2_r5", v, 32'hFFFF_FFFE);
        rd(6, v); chk("t2_r6", v, 2);
        // 3: same destination in slots 0 and 2
        send({z, sl(1, 4, 1, 0, 0, 3), z, sl(1, 4, 1, 0, 0, 9)});
        repeat (2) tick();
        rd(1, v); chk("t3_r1", v, 3);
        chk("t3_waw", waw_o, 1'b1);
        chk("t3_mask", last_mask, 4'b0101);
        // 4: slots read the pre-bundle RF
        send({z, z, z, sl(1, 4, 1, 0, 0, 5)});
        send({z, z, sl(1, 2, 2, 1, 0, 1), sl(1, 4, 1, 0, 0, 1)});
        repeat (2) tick();
        rd(2, v); chk("t4_r2", v, 6);
        rd(1, v); chk("t4_r1", v, 1);
        // 5: hold with two bundles in flight
        send({z, z, z, sl(1, 4, 6, 0, 0, 19'h11)});
        send({z, z, z, sl(1, 2, 7, 6, 0, 1)});
        hold_i = 1'b1;
        bundle_valid_i = 1'b1;
        bundle_i = {z, z, z, sl(1, 4, 0, 0, 0, 19'h7)};
        repeat (3) tick();
        rd(6, v); chk("t5_r6_held", v, 2);
        hold_i = 1'b0;
        bundle_valid_i = 1'b0;
        repeat (2) tick();
        rd(6, v); chk("t5_r6", v, 32'h11);
        rd(7, v); chk("t5_r7", v, 32'h12);
        // 6: multiply, then reset clears everything
        send({z, sl(1, 4, 3, 0, 0, 19'h55), sl(1, 4, 2, 0, 0, 19'h10000), sl(1, 4, 1, 0, 0, 19'h10000)});
        send({z, z, z, sl(1, 1, 3, 1, 2, 0)});
        repeat (2) tick();
        rd(3, v);
`ifdef VLIW_MUL_EN
        chk("t6_r3", v, 0);
        chk("t6_ill", illegal_o, 1'b0);
`else
        chk("t6_r3", v, 32'h55);
        chk("t6_ill", illegal_o, 1'b1);
        chk("t6_mask", last_mask, 4'b0000);
`endif
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("t6_rst_cnt", retire_cnt_o, 0);
        chk("t6_rst_ill", illegal_o, 1'b0);
        chk("t6_rst_waw", waw_o, 1'b0);
        rd(3, v); chk("t6_rst_r3", v, 0);
        // random traffic with holds, bubbles and one mid-stream reset
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < NS; s++)
                rb[s*SW +: SW] = sl(($urandom % 5) != 0, 3'($urandom), 3'($urandom),
                                    3'($urandom), 3'($urandom), 19'($urandom));
            bundle_i       = rb;
            bundle_valid_i = ($urandom % 4) != 0;
            hold_i         = ($urandom % 7) == 0;
            rstn           = (i != 200);
            tick();
        end
        rstn = 1'b1;
        hold_i = 1'b0;
        bundle_valid_i = 1'b0;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
